jt6295_rom_sched: RTL and testbench
===================================

// Module: jt6295_rom_sched
// PURPOSE
//  Round-robin scheduler sharing the single external ADPCM ROM port between NSLOT requesters
//  (channel fetch, phrase-table fetch, debug/spare).
//  Each slot has a cs/addr request and a registered byte with an ok flag.
//  One ROM access is in flight at a time.
//  Sits between jt6295 sub-blocks and the top-level rom_addr/rom_data/rom_ok pins.
// PARAMETERS
//  NSLOT  4   number of requesters (2..8)
//  AW     18  ROM address width
//  DW     8   ROM data width
// PORTS
//  clk        in   1         system clock; all state changes on rising edge
//  rst        in   1         asynchronous, active-low reset
//  slot_cs    in   NSLOT     per-slot request; hold high until slot_ok
//  slot_addr  in   NSLOT*AW  per-slot address, slot i at [i*AW+:AW]
//  slot_dout  out  NSLOT*DW  per-slot latched data, slot i at [i*DW+:DW]
//  slot_ok    out  NSLOT     slot_dout valid for the current slot_addr
//  rom_cs     out  1         external access active
//  rom_addr   out  AW        external ROM address (registered)
//  rom_data   in   DW        external ROM data
//  rom_ok     in   1         rom_data valid for rom_addr
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rom_cs=0, rom_addr=0, rr_ptr=0, all last_addr=0,
//   valid=0, slot_dout=0, slot_ok=0.
//  Hit logic, combinational: slot_ok[i] = slot_cs[i] & valid[i] & (slot_addr_i==last_addr[i]).
//   A change of address or a low cs drops ok in the same cycle.
//   slot_dout holds its value while cs is low.
//  pending[i] = slot_cs[i] & ~slot_ok[i].
//  FSM:
//   IDLE: if |pending, grant = first pending slot searching from rr_ptr upward with wrap.
//     Then grant_q<=grant, rom_addr<=slot_addr_grant, rom_cs<=1, go to WAIT.
//     Otherwise stay in IDLE with rom_cs=0.
//   WAIT: exactly 1 cycle; rom_ok ignored because it is stale from the previous address.
//     Go to READ.
//   READ: stay until rom_ok=1. Then:
//     slot_dout[grant_q]<=rom_data, last_addr[grant_q]<=rom_addr, valid[grant_q]<=1,
//     rom_cs<=0, rr_ptr<=grant_q+1 (mod NSLOT), go to IDLE.
//  Latency: request seen in IDLE at cycle 0 with rom_ok already high gives slot_ok=1 at cycle 3.
//   Each extra rom_ok low cycle in READ adds 1.
//  Back-to-back: IDLE is entered for 1 cycle between accesses, so peak rate is 1 byte / 3 clk.
//  Boundaries:
//   - Requester drops cs or changes addr while in WAIT/READ: the access still completes.
//     Data is stored tagged with the fetched address. The mismatch keeps ok low, and the slot
//     re-requests through normal arbitration.
//   - All slots pending: strict rotation. A slot waits at most NSLOT-1 accesses.
//   - rr_ptr wrap: NSLOT-1 -> 0. Non-power-of-2 NSLOT wraps explicitly, never to an
//     unused index.
//   - Grant and completion for the same slot in one cycle cannot occur: grant is only issued
//     in IDLE.
//   - rom_addr is held stable for the whole access; the FSM never changes it outside IDLE.
// CONFIGURATION
//  JT6295_ROMPRIO_EN defined:
//   - Slot 0 (channel fetch) has fixed top priority and is granted whenever pending in IDLE.
//   - The remaining slots rotate round-robin among themselves.
//   - rr_ptr only advances on non-zero grants.
//  JT6295_ROMPRIO_EN undefined: pure round-robin over all NSLOT slots, as described above.
// TESTING
//  1 Reset: rst=0 mid-READ -> rom_cs=0, rom_addr=0, all slot_ok=0 immediately (async).
//    Release -> IDLE.
//  2 Single: slot1 cs=1 addr=18'h00123, rom_ok=1, rom_data=8'hA5 -> rom_addr=18'h00123 at
//    cycle 1, slot_ok[1]=1 and dout1=8'hA5 at cycle 3.
//    Held request -> no new rom_cs.
//  3 Round-robin: all 4 slots cs=1 with distinct addrs, rr_ptr=2 -> service order 2,3,0,1.
//    With JT6295_ROMPRIO_EN and slot0 re-requesting each time -> 0,2,0,3,...
//  4 Stale ok: rom_ok=1 in WAIT, then rom_ok=0 for 5 cycles in READ, then 1 -> data not
//    latched until rom_ok is seen in READ.
//    slot_ok rises 5 cycles later than in test 2.
//  5 Abort: slot2 changes addr 18'h100->18'h200 during READ -> dout2 captures data for
//    18'h100, slot_ok[2] stays 0.
//    A new access to 18'h200 follows and ok rises after it.
//  6 Hit: slot3 addr toggles 18'h40 -> 18'h41 -> 18'h40 -> slot_ok[3] falls and rises
//    combinationally. Each address that differs from last_addr triggers exactly one
//    ROM access.

Source files
------------

// File: rtl/jt6295_rom_sched.sv
// jt6295_rom_sched
//   Round-robin scheduler that shares the single external ADPCM ROM port
//   between NSLOT requesters (channel fetch, phrase-table fetch, debug/spare).
//   Only one ROM access is in flight at a time. Each slot keeps its own
//   latched byte, tagged with the address it was fetched from. A slot reads
//   as "ok" while its request matches that tag.
//
//   Parameters:
//     NSLOT  number of requesters (2..8)
//     AW     ROM address width
//     DW     ROM data width
//
//   Ports:
//     clk        system clock; all state changes on the rising edge
//     rst        asynchronous, active-low reset
//     slot_cs    per-slot request; held high until slot_ok
//     slot_addr  per-slot address, slot i at [i*AW +: AW]
//     slot_dout  per-slot latched data, slot i at [i*DW +: DW]
//     slot_ok    slot_dout is valid for the current slot_addr
//     rom_cs     external access active
//     rom_addr   external ROM address (registered, stable for the whole access)
//     rom_data   external ROM data
//     rom_ok     rom_data valid for rom_addr
//
//   Build option:
//     JT6295_ROMPRIO_EN  slot 0 gets fixed top priority. Slots 1..NSLOT-1
//                        rotate among themselves. Without the macro, all
//                        slots rotate round-robin.

module jt6295_rom_sched #(
    parameter int unsigned NSLOT = 4,
    parameter int unsigned AW    = 18,
    parameter int unsigned DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSLOT-1:0]    slot_cs,
    input  logic [NSLOT*AW-1:0] slot_addr,
    output logic [NSLOT*DW-1:0] slot_dout,
    output logic [NSLOT-1:0]    slot_ok,
    output logic                rom_cs,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data,
    input  logic                rom_ok
);

    localparam int unsigned GW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    typedef logic [GW-1:0] idx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ
    } state_t;

    state_t          state_q,  state_d;
    idx_t            grant_q,  grant_d;
    idx_t            rr_ptr_q, rr_ptr_d;
    logic            rom_cs_q, rom_cs_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [NSLOT-1:0] valid_q, valid_d;
    logic [AW-1:0]   last_addr_q [NSLOT];
    logic [AW-1:0]   last_addr_d [NSLOT];
    logic [DW-1:0]   dout_q [NSLOT];
    logic [DW-1:0]   dout_d [NSLOT];

    logic [NSLOT-1:0] pending;
    logic             grant_found;
    idx_t             grant_idx;
    idx_t             rr_next;

    // Hit logic is purely combinational. An address change or a low cs
    // drops ok in the same cycle. The data register itself is untouched.
    always_comb begin
        slot_ok   = '0;
        slot_dout = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            slot_ok[i] = slot_cs[i] & valid_q[i] &
                         (slot_addr[i*AW +: AW] == last_addr_q[i]);
            slot_dout[i*DW +: DW] = dout_q[i];
        end
    end

    assign pending = slot_cs & ~slot_ok;

    // Search for the first pending slot, starting at rr_ptr and wrapping.
    // The wrap is explicit, so a non-power-of-2 NSLOT never lands on an
    // index that no slot uses.
    always_comb begin
        int unsigned cand;
        int unsigned base;
        cand        = 0;
        base        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
`ifdef JT6295_ROMPRIO_EN
        if (pending[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end else begin
            // Rotate over slots 1..NSLOT-1 only. rr_ptr is 0 only after reset.
            base = (rr_ptr_q == '0) ? 1 : 32'(rr_ptr_q);
            for (int unsigned off = 0; off < NSLOT - 1; off++) begin
                cand = base + off;
                if (cand >= NSLOT) cand = cand - (NSLOT - 1);
                if (!grant_found && pending[idx_t'(cand)]) begin
                    grant_found = 1'b1;
                    grant_idx   = idx_t'(cand);
                end
            end
        end
`else
        base = 32'(rr_ptr_q);
        for (int unsigned off = 0; off < NSLOT; off++) begin
            cand = base + off;
            if (cand >= NSLOT) cand = cand - NSLOT;
            if (!grant_found && pending[idx_t'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = idx_t'(cand);
            end
        end
`endif
    end

    // Pointer value after the current grant completes.
    always_comb begin
`ifdef JT6295_ROMPRIO_EN
        if (grant_q == '0)
            rr_next = rr_ptr_q;
        else if (grant_q == idx_t'(NSLOT - 1))
            rr_next = idx_t'(1);
        else
            rr_next = grant_q + 1'b1;
`else
        if (grant_q == idx_t'(NSLOT - 1))
            rr_next = '0;
        else
            rr_next = grant_q + 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        rom_cs_d    = rom_cs_q;
        rom_addr_d  = rom_addr_q;
        valid_d     = valid_q;
        last_addr_d = last_addr_q;
        dout_d      = dout_q;
        case (state_q)
            S_IDLE: begin
                rom_cs_d = 1'b0;
                if (grant_found) begin
                    grant_d    = grant_idx;
                    rom_addr_d = slot_addr[32'(grant_idx)*AW +: AW];
                    rom_cs_d   = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            // rom_ok still refers to the previous address here, so skip it.
            S_WAIT: state_d = S_READ;
            S_READ: begin
                if (rom_ok) begin
                    dout_d[grant_q]      = rom_data;
                    last_addr_d[grant_q] = rom_addr_q;
                    valid_d[grant_q]     = 1'b1;
                    rom_cs_d             = 1'b0;
                    rr_ptr_d             = rr_next;
                    state_d              = S_IDLE;
                end
            end
            default: begin
                rom_cs_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            rom_cs_q    <= 1'b0;
            rom_addr_q  <= '0;
            valid_q     <= '0;
            last_addr_q <= '{default: '0};
            dout_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            rom_cs_q    <= rom_cs_d;
            rom_addr_q  <= rom_addr_d;
            valid_q     <= valid_d;
            last_addr_q <= last_addr_d;
            dout_q      <= dout_d;
        end
    end

    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_jt6295_rom_sched.sv
module tb_jt6295_rom_sched;

    localparam int unsigned NSLOT = 4;
    localparam int unsigned AW    = 18;
    localparam int unsigned DW    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NSLOT-1:0]    slot_cs;
    logic [NSLOT*AW-1:0] slot_addr;
    logic [NSLOT*DW-1:0] slot_dout;
    logic [NSLOT-1:0]    slot_ok;
    logic                rom_cs;
    logic [AW-1:0]       rom_addr;
    logic [DW-1:0]       rom_data;
    logic                rom_ok;

    int errors = 0;
    int checks = 0;
    int unsigned access_cnt = 0;
    logic [AW-1:0] exp_q[$];

    jt6295_rom_sched #(.NSLOT(NSLOT), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .slot_cs   (slot_cs),
        .slot_addr (slot_addr),
        .slot_dout (slot_dout),
        .slot_ok   (slot_ok),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_ok    (rom_ok)
    );

    always #5 clk = ~clk;

    // ROM contents model: 0x00123 -> 0xA5, 0x100 -> 0x86, 0x200 -> 0x85
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h87;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    function automatic logic [DW-1:0] dout_of(input int s);
        return slot_dout[s*DW +: DW];
    endfunction

    task automatic set_slot(input int s, input logic cs, input logic [AW-1:0] a);
        slot_cs[s]           = cs;
        slot_addr[s*AW +: AW] = a;
    endtask

    task automatic wait_ok(input int s, input int maxc, output bit got);
        got = 1'b0;
        for (int n = 0; n < maxc && !got; n++) begin
            @(negedge clk);
            if (slot_ok[s] === 1'b1) got = 1'b1;
        end
    endtask

    // Access monitor: pops the expected address at every access start and
    // requires rom_addr to stay put while rom_cs is high.
    logic          mon_prev_cs = 1'b0;
    logic [AW-1:0] mon_held    = '0;
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (rst !== 1'b1) begin
            mon_prev_cs = 1'b0;
        end else begin
            if (rom_cs === 1'b1 && !mon_prev_cs) begin
                access_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL access_order: unexpected access rom_addr=%h, none expected", rom_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (rom_addr !== e) begin
                        errors++;
                        $display("FAIL access_order: rom_addr=%h expected %h", rom_addr, e);
                    end
                end
                mon_held = rom_addr;
            end else if (rom_cs === 1'b1 && mon_prev_cs) begin
                checks++;
                if (rom_addr !== mon_held) begin
                    errors++;
                    $display("FAIL rom_addr_stable: rom_addr=%h expected %h", rom_addr, mon_held);
                end
            end
            mon_prev_cs = (rom_cs === 1'b1);
        end
    end

    task automatic test_reset();
        rst = 1'b0; slot_cs = '0; slot_addr = '0; rom_ok = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b expected 0", rom_cs); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
        checks++; if (slot_ok !== '0) begin errors++; $display("FAIL reset_slot_ok: got %b expected 0", slot_ok); end
        checks++; if (slot_dout !== '0) begin errors++; $display("FAIL reset_slot_dout: got %h expected 0", slot_dout); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_idle: rom_cs=%b expected 0", rom_cs); end
    endtask

    task automatic test_single();
        rom_ok = 1'b1;
        set_slot(1, 1'b1, 18'h00123);
        exp_q.push_back(18'h00123);
        @(negedge clk);
        checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL single_rom_cs_c1: got %b expected 1", rom_cs); end
        checks++; if (rom_addr !== 18'h00123) begin errors++; $display("FAIL single_rom_addr_c1: got %h expected 00123", rom_addr); end
        @(negedge clk);
        checks++; if (slot_ok[1] !== 1'b0) begin errors++; $display("FAIL single_ok_c2: got %b expected 0", slot_ok[1]); end
        @(negedge clk);
        checks++; if (slot_ok[1] !== 1'b1) begin errors++; $display("FAIL single_ok_c3: got %b expected 1", slot_ok[1]); end
        checks++; if (dout_of(1) !== 8'hA5) begin errors++; $display("FAIL single_dout_c3: got %h expected a5", dout_of(1)); end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (rom_cs !== 1'b0 || slot_ok[1] !== 1'b1) begin
                errors++;
                $display("FAIL single_held: rom_cs=%b ok=%b expected rom_cs=0 ok=1", rom_cs, slot_ok[1]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a [NSLOT];
        bit got;
        for (int i = 0; i < int'(NSLOT); i++) a[i] = AW'(18'h01000 + i * 18'h00011);
        for (int i = 0; i < int'(NSLOT); i++) set_slot(i, 1'b1, a[i]);
`ifdef JT6295_ROMPRIO_EN
        exp_q.push_back(a[0]); exp_q.push_back(a[2]); exp_q.push_back(a[3]); exp_q.push_back(a[1]);
`else
        exp_q.push_back(a[2]); exp_q.push_back(a[3]); exp_q.push_back(a[0]); exp_q.push_back(a[1]);
`endif
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (slot_ok === 4'hF) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL rr_all_ok: slot_ok=%b expected 1111 within 40 cycles", slot_ok); end
        for (int i = 0; i < int'(NSLOT); i++) begin
            checks++;
            if (dout_of(i) !== rom_fn(a[i])) begin
                errors++; $display("FAIL rr_dout%0d: got %h expected %h", i, dout_of(i), rom_fn(a[i]));
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drained: %0d accesses left, expected 0", exp_q.size()); end
        slot_cs = '0;
        #1;
        checks++; if (slot_ok !== '0) begin errors++; $display("FAIL rr_cs_drop: slot_ok=%b expected 0000", slot_ok); end
        checks++; if (dout_of(3) !== rom_fn(a[3])) begin errors++; $display("FAIL rr_dout_hold: got %h expected %h", dout_of(3), rom_fn(a[3])); end
        @(negedge clk);
    endtask

    task automatic test_stale_ok();
        logic [DW-1:0] old;
        old = dout_of(0);
        rom_ok = 1'b1;
        set_slot(0, 1'b1, 18'h00055);
        exp_q.push_back(18'h00055);
        repeat (2) @(negedge clk);
        checks++; if (slot_ok[0] !== 1'b0) begin errors++; $display("FAIL stale_wait_ignored: ok=%b expected 0", slot_ok[0]); end
        rom_ok = 1'b0;
        for (int n = 3; n <= 7; n++) begin
            @(negedge clk);
            checks++;
            if (slot_ok[0] !== 1'b0 || dout_of(0) !== old) begin
                errors++; $display("FAIL stale_read_hold c%0d: ok=%b dout=%h expected ok=0 dout=%h", n, slot_ok[0], dout_of(0), old);
            end
        end
        rom_ok = 1'b1;
        @(negedge clk);
        checks++; if (slot_ok[0] !== 1'b1) begin errors++; $display("FAIL stale_ok_c8: got %b expected 1", slot_ok[0]); end
        checks++; if (dout_of(0) !== 8'hD2) begin errors++; $display("FAIL stale_dout_c8: got %h expected d2", dout_of(0)); end
        slot_cs[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit got;
        rom_ok = 1'b0;
        set_slot(2, 1'b1, 18'h00100);
        exp_q.push_back(18'h00100);
        repeat (3) @(negedge clk);
        set_slot(2, 1'b1, 18'h00200);
        exp_q.push_back(18'h00200);
        @(negedge clk);
        rom_ok = 1'b1;
        @(negedge clk);
        checks++; if (slot_ok[2] !== 1'b0) begin errors++; $display("FAIL abort_ok_low: got %b expected 0", slot_ok[2]); end
        checks++; if (dout_of(2) !== 8'h86) begin errors++; $display("FAIL abort_dout_old: got %h expected 86", dout_of(2)); end
        wait_ok(2, 10, got);
        checks++; if (!got) begin errors++; $display("FAIL abort_refetch_ok: slot_ok[2]=%b expected 1 within 10 cycles", slot_ok[2]); end
        checks++; if (dout_of(2) !== 8'h85) begin errors++; $display("FAIL abort_dout_new: got %h expected 85", dout_of(2)); end
        slot_cs[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hit();
        bit got;
        int unsigned base_cnt;
        base_cnt = access_cnt;
        rom_ok = 1'b1;
        set_slot(3, 1'b1, 18'h00040);
        exp_q.push_back(18'h00040);
        wait_ok(3, 10, got);
        checks++; if (!got || dout_of(3) !== 8'hC7) begin errors++; $display("FAIL hit_first: ok=%b dout=%h expected 1 c7", slot_ok[3], dout_of(3)); end
        set_slot(3, 1'b1, 18'h00041);
        exp_q.push_back(18'h00041);
        #1;
        checks++; if (slot_ok[3] !== 1'b0) begin errors++; $display("FAIL hit_fall_41: got %b expected 0", slot_ok[3]); end
        wait_ok(3, 10, got);
        checks++; if (!got || dout_of(3) !== 8'hC6) begin errors++; $display("FAIL hit_41: ok=%b dout=%h expected 1 c6", slot_ok[3], dout_of(3)); end
        set_slot(3, 1'b1, 18'h00040);
        exp_q.push_back(18'h00040);
        #1;
        checks++; if (slot_ok[3] !== 1'b0) begin errors++; $display("FAIL hit_fall_40: got %b expected 0", slot_ok[3]); end
        wait_ok(3, 10, got);
        checks++; if (!got || dout_of(3) !== 8'hC7) begin errors++; $display("FAIL hit_40: ok=%b dout=%h expected 1 c7", slot_ok[3], dout_of(3)); end
        @(negedge clk);
        slot_cs[3] = 1'b0;
        #1;
        checks++; if (slot_ok[3] !== 1'b0 || dout_of(3) !== 8'hC7) begin errors++; $display("FAIL hit_cs_low: ok=%b dout=%h expected 0 c7", slot_ok[3], dout_of(3)); end
        repeat (3) @(negedge clk);
        slot_cs[3] = 1'b1;
        #1;
        checks++; if (slot_ok[3] !== 1'b1) begin errors++; $display("FAIL hit_cs_rise: got %b expected 1", slot_ok[3]); end
        repeat (4) @(negedge clk);
        checks++; if (access_cnt - base_cnt != 3) begin errors++; $display("FAIL hit_access_count: got %0d expected 3", access_cnt - base_cnt); end
        slot_cs[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit got;
        set_slot(1, 1'b1, 18'h01011);
        rom_ok = 1'b0;
        set_slot(2, 1'b1, 18'h00300);
        exp_q.push_back(18'h00300);
        repeat (3) @(negedge clk);
        checks++; if (rom_cs !== 1'b1 || slot_ok[1] !== 1'b1) begin errors++; $display("FAIL areset_pre: rom_cs=%b ok1=%b expected 1 1", rom_cs, slot_ok[1]); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL areset_rom_cs: got %b expected 0", rom_cs); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL areset_rom_addr: got %h expected 0", rom_addr); end
        checks++; if (slot_ok !== '0) begin errors++; $display("FAIL areset_slot_ok: got %b expected 0000", slot_ok); end
        @(negedge clk);
        slot_cs = '0; rom_ok = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL areset_idle: rom_cs=%b expected 0", rom_cs); end
        end
        set_slot(1, 1'b1, 18'h01011);
        exp_q.push_back(18'h01011);
        #1;
        checks++; if (slot_ok[1] !== 1'b0) begin errors++; $display("FAIL areset_valid_cleared: ok1=%b expected 0", slot_ok[1]); end
        wait_ok(1, 10, got);
        checks++; if (!got || dout_of(1) !== rom_fn(18'h01011)) begin errors++; $display("FAIL areset_refetch: ok=%b dout=%h expected 1 %h", slot_ok[1], dout_of(1), rom_fn(18'h01011)); end
        slot_cs = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stale_ok();
        test_abort();
        test_hit();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drained: %0d accesses never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
